mini_calc_seq: RTL

- Front-end sequencer feeding the mini calculator stage.
- Buffers {instruction, A, B} commands in a small FIFO and issues one at a time to the calculator's Instruction/InputA/InputB.
- Waits a fixed pipeline latency, then captures the calculator's two outputs and presents them on a valid/ready result port.
- Decouples a bursty command producer from the calculator and from a possibly stalling result consumer.

---
 rtl/mini_calc_seq.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/mini_calc_seq.sv
// Command FIFO + issue sequencer in front of the mini calculator; results are held on a valid/ready port.
// Optional build macro MINI_CALC_SEQ_SKIP_NOP_EN drops queued NOP commands instead of issuing them.
module mini_calc_seq #(
    parameter int                         INPUT_BIT_WIDTH = 8,
    parameter int                         INSTR_BIT_WIDTH = 4,
    parameter int                         FIFO_DEPTH      = 4,
    parameter int                         CALC_LATENCY    = 2,
    parameter logic [INSTR_BIT_WIDTH-1:0] CODE_INSTR_NOP  = 4'b1111
) (
    input  logic                             Clk,
    input  logic                             ResetN,
    input  logic                             InValid,
    output logic                             InReady,
    input  logic [INSTR_BIT_WIDTH-1:0]       InInstruction,
    input  logic [INPUT_BIT_WIDTH-1:0]       InA,
    input  logic [INPUT_BIT_WIDTH-1:0]       InB,
    output logic [INSTR_BIT_WIDTH-1:0]       CalcInstruction,
    output logic [INPUT_BIT_WIDTH-1:0]       CalcInputA,
    output logic [INPUT_BIT_WIDTH-1:0]       CalcInputB,
    input  logic [INPUT_BIT_WIDTH-1:0]       CalcOutputA,
    input  logic [INPUT_BIT_WIDTH-1:0]       CalcOutputB,
    output logic                             OutValid,
    input  logic                             OutReady,
    output logic [INPUT_BIT_WIDTH-1:0]       OutA,
    output logic [INPUT_BIT_WIDTH-1:0]       OutB,
    output logic [$clog2(FIFO_DEPTH):0]      QueueLevel,
    output logic                             Busy,
    output logic [1:0]                       DbgState
);
    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // valid is never withdrawn and payload never changes until that edge.
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(CALC_LATENCY + 1);
    localparam int CMD_W = INSTR_BIT_WIDTH + 2 * INPUT_BIT_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_RESULT = 2'd2
    } state_t;

    state_t                       r_state;
    state_t                       w_next_state;
    logic [CMD_W-1:0]             r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]             r_wr_ptr;
    logic [PTR_W-1:0]             r_rd_ptr;
    logic [LVL_W-1:0]             r_level;
    logic [CNT_W-1:0]             r_cnt;
    logic                         w_push;
    logic                         w_pop;
    logic                         w_issue;
    logic                         w_capture;
    logic                         w_empty;
    logic                         w_head_nop;
    logic [CMD_W-1:0]             w_head;
    logic [INSTR_BIT_WIDTH-1:0]   w_head_instr;
    logic [INPUT_BIT_WIDTH-1:0]   w_head_a;
    logic [INPUT_BIT_WIDTH-1:0]   w_head_b;

    assign InReady      = (r_level != LVL_W'(FIFO_DEPTH));
    assign w_push       = InValid && InReady;
    assign w_empty      = (r_level == '0);
    assign w_head       = r_mem[r_rd_ptr];
    assign w_head_instr = w_head[CMD_W-1 -: INSTR_BIT_WIDTH];
    assign w_head_a     = w_head[2*INPUT_BIT_WIDTH-1 -: INPUT_BIT_WIDTH];
    assign w_head_b     = w_head[INPUT_BIT_WIDTH-1:0];
`ifdef MINI_CALC_SEQ_SKIP_NOP_EN
    assign w_head_nop   = (w_head_instr == CODE_INSTR_NOP);
`else
    assign w_head_nop   = 1'b0;
`endif
    assign QueueLevel   = r_level;
    assign Busy         = (r_state != S_IDLE) || !w_empty;
    assign DbgState     = r_state;

    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_issue      = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    if (!w_head_nop) begin
                        w_issue      = 1'b1;
                        w_next_state = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_capture    = 1'b1;
                    w_next_state = S_RESULT;
                end
            end
            S_RESULT: begin
                if (OutReady) begin
                    w_next_state = S_IDLE;
                    // Chaining the next issue onto the accept edge keeps the pipe at L+1 cycles/op.
                    if (!w_empty) begin
                        w_pop = 1'b1;
                        if (!w_head_nop) begin
                            w_issue      = 1'b1;
                            w_next_state = S_WAIT;
                        end
                    end
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {InInstruction, InA, InB};
        end
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            r_state         <= S_IDLE;
            r_cnt           <= '0;
            CalcInstruction <= CODE_INSTR_NOP;
            CalcInputA      <= '0;
            CalcInputB      <= '0;
            OutValid        <= 1'b0;
            OutA            <= '0;
            OutB            <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_issue) begin
                r_cnt           <= CNT_W'(CALC_LATENCY);
                CalcInstruction <= w_head_instr;
                CalcInputA      <= w_head_a;
                CalcInputB      <= w_head_b;
            end else if (w_capture) begin
                CalcInstruction <= CODE_INSTR_NOP;
                CalcInputA      <= '0;
                CalcInputB      <= '0;
            end
            if (r_state == S_WAIT && !w_capture) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_capture) begin
                OutValid <= 1'b1;
                OutA     <= CalcOutputA;
                OutB     <= CalcOutputB;
            end else if (r_state == S_RESULT && OutReady) begin
                OutValid <= 1'b0;
            end
        end
    end
endmodule
